// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped UART transmitter with TXD/CON registers and level interrupt
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_periph #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        UART_TX,
    output logic        irqout
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] CON_ADDR  = BASE_ADDR + 32'd8;

    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  txd_q, txd_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        tx_q, tx_d;

    logic txd_hit, con_hit, period_end, set_done, busy;
    logic unused_wdata;

    assign txd_hit      = (addr == BASE_ADDR);
    assign con_hit      = (addr == CON_ADDR);
    assign period_end   = (baud_q == BAUD_LAST);
    assign busy         = (state_q != ST_IDLE);
    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        set_done  = 1'b0;

        // Counter restarts on every state entry so each bit period is exactly CLKS_PER_BIT.
        if (state_q != ST_IDLE) begin
            baud_d = period_end ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr && txd_hit) begin
                    state_d = ST_START;
                    shift_d = wdata[7:0];
                    txd_d   = wdata[7:0];
                    baud_d  = 16'd0;
                end
            end
            ST_START: begin
                if (period_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (period_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (period_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (period_end) begin
                    state_d  = ST_IDLE;
                    set_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr && con_hit) begin
            irq_en_d = wdata[0];
            if (wdata[1]) done_d = 1'b0;
        end
        // Frame completion overrides a software clear landing on the same edge.
        if (set_done) done_d = 1'b1;

        // Line level is derived from the next state so UART_TX is a glitch-free flop.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^shift_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 8'h00;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (rd && txd_hit)      rdata = {24'h0, txd_q};
        else if (rd && con_hit) rdata = {29'h0, busy, done_q, irq_en_q};
    end

    assign UART_TX = tx_q;
    assign irqout  = done_q & irq_en_q;

endmodule
